// File: rtl/code_lock_fsm.sv
// code_lock_fsm: programmable button-code lock with retry counting, lockout and idle timeout on one 7-seg digit
module code_lock_fsm #(
   parameter int CODE_LEN = 4,
   parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE = 8'h2B,
   parameter int MAX_TRIES = 3,
   parameter int TIMEOUT_CYC = 1000,
   parameter int LOCK_CYC = 5000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Ubtn,
   input  logic       Dbtn,
   input  logic       Lbtn,
   input  logic       Rbtn,
   input  logic       prog_req,
   output logic [6:0] SSG_D,
   output logic [2:0] SSG_EN,
   output logic       unlocked,
   output logic       locked_out,
   output logic [2:0] fail_count
);
   localparam int CW = 2 * CODE_LEN;
   localparam int TW = $clog2((TIMEOUT_CYC > LOCK_CYC ? TIMEOUT_CYC : LOCK_CYC) + 1);
   localparam logic [6:0] DIGIT [9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};
   typedef enum logic [2:0] {ENTRY, OPEN, PROG, FAIL, LOCKOUT} state_t;
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d, pcnt_q, pcnt_d, btn_q, rise, base_cnt;
   logic mis_q, mis_d, prog_q, base_mis, press, multi, prog_edge, retry;
   logic [2:0] fail_q, fail_d;
   logic [CW-1:0] code_q, code_d, shadow_q, shadow_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [1:0] val, exp_v;
   logic [6:0] ssg_q, ssg_d;
   logic unl_q, unl_d, lo_q, lo_d;
   int sh;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ENTRY;
         cnt_q <= '0;
         pcnt_q <= '0;
         mis_q <= 1'b0;
         fail_q <= '0;
         code_q <= DEFAULT_CODE;
         shadow_q <= '0;
         tmr_q <= '0;
         btn_q <= '0;
         prog_q <= 1'b0;
         ssg_q <= DIGIT[0];
         unl_q <= 1'b0;
         lo_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         pcnt_q <= pcnt_d;
         mis_q <= mis_d;
         fail_q <= fail_d;
         code_q <= code_d;
         shadow_q <= shadow_d;
         tmr_q <= tmr_d;
         btn_q <= {Ubtn, Dbtn, Lbtn, Rbtn};
         prog_q <= prog_req;
         ssg_q <= ssg_d;
         unl_q <= unl_d;
         lo_q <= lo_d;
      end
   end
   always_comb begin
      rise = {Ubtn, Dbtn, Lbtn, Rbtn} & ~btn_q;
      press = |rise;
      multi = (rise & (rise - 4'd1)) != 4'd0;
      val = {rise[1] | rise[0], rise[2] | rise[0]};
      prog_edge = prog_req & ~prog_q;
      retry = state_q == FAIL;
      base_cnt = retry ? 4'd0 : cnt_q;
      base_mis = retry ? 1'b0 : mis_q;
      sh = 2 * (CODE_LEN - 1 - int'(base_cnt));
      exp_v = code_q[sh+:2];
      state_d = state_q;
      cnt_d = cnt_q;
      pcnt_d = pcnt_q;
      mis_d = mis_q;
      fail_d = fail_q;
      code_d = code_q;
      shadow_d = shadow_q;
      tmr_d = tmr_q;
      case (state_q)
         ENTRY, FAIL: begin
            if (retry && int'(fail_q) == MAX_TRIES) begin
               state_d = LOCKOUT;
               tmr_d = '0;
            end else if (press) begin
               state_d = ENTRY;
               cnt_d = base_cnt + 4'd1;
               mis_d = base_mis | multi | (val != exp_v);
               tmr_d = '0;
               if (cnt_d == 4'(CODE_LEN)) begin
                  state_d = mis_d ? FAIL : OPEN;
                  fail_d = !mis_d ? 3'd0 : (fail_q == 3'd7) ? fail_q : fail_q + 3'd1;
                  cnt_d = '0;
                  mis_d = 1'b0;
               end
            end else if (!retry && cnt_q != 4'd0) begin
               tmr_d = tmr_q + 1'b1;
               if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
                  cnt_d = '0;
                  mis_d = 1'b0;
                  tmr_d = '0;
               end
            end
         end
         OPEN: begin
            if (prog_edge) begin
               state_d = PROG;
               pcnt_d = '0;
               tmr_d = '0;
            end
         end
         PROG: begin
            // an ambiguous multi-button press aborts rather than being guessed at
            if (press && multi) state_d = OPEN;
            else if (press) begin
               shadow_d = (shadow_q << 2) | CW'(val);
               pcnt_d = pcnt_q + 4'd1;
               tmr_d = '0;
               if (pcnt_d == 4'(CODE_LEN)) begin
                  code_d = shadow_d;
                  state_d = ENTRY;
                  cnt_d = '0;
                  mis_d = 1'b0;
               end
            end else if (tmr_q == TW'(TIMEOUT_CYC - 1)) state_d = OPEN;
            else tmr_d = tmr_q + 1'b1;
         end
         LOCKOUT: begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == TW'(LOCK_CYC - 1)) begin
               state_d = ENTRY;
               cnt_d = '0;
               mis_d = 1'b0;
               fail_d = '0;
               tmr_d = '0;
            end
         end
         default: state_d = ENTRY;
      endcase
   end
   always_comb begin
      ssg_d = state_q == OPEN ? 7'b0010000 :
              state_q == PROG ? 7'b0001100 :
              state_q == FAIL ? 7'b0000110 :
              state_q == LOCKOUT ? 7'b1000111 : DIGIT[cnt_q];
      unl_d = state_q == OPEN;
      lo_d = state_q == LOCKOUT;
   end
   assign SSG_D = ssg_q;
   assign SSG_EN = 3'b110;
   assign unlocked = unl_q;
   assign locked_out = lo_q;
   assign fail_count = fail_q;
endmodule

// File: tb/tb_code_lock_fsm.sv
// tb_code_lock_fsm: directed checks of entry, failure, lockout, programming, timeouts and reset
module tb_code_lock_fsm;
   logic clk = 1'b0, reset = 1'b1, Ubtn = 1'b0, Dbtn = 1'b0, Lbtn = 1'b0, Rbtn = 1'b0, prog_req = 1'b0;
   logic [6:0] SSG_D;
   logic [2:0] SSG_EN, fail_count;
   logic unlocked, locked_out;
   int vectors = 0, miscompares = 0;
   localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
   localparam logic [6:0] G9 = 7'b0010000, GP = 7'b0001100, GE = 7'b0000110, GL = 7'b1000111;
   localparam logic [3:0] U = 4'b1000, D = 4'b0100, L = 4'b0010, R = 4'b0001;
   code_lock_fsm #(.CODE_LEN(4), .DEFAULT_CODE(8'h2B), .MAX_TRIES(3), .TIMEOUT_CYC(16), .LOCK_CYC(32)) dut (
      .clk(clk), .reset(reset), .Ubtn(Ubtn), .Dbtn(Dbtn), .Lbtn(Lbtn), .Rbtn(Rbtn), .prog_req(prog_req),
      .SSG_D(SSG_D), .SSG_EN(SSG_EN), .unlocked(unlocked), .locked_out(locked_out), .fail_count(fail_count));
   always #10 clk = ~clk;
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic press(input logic [3:0] b);
      {Ubtn, Dbtn, Lbtn, Rbtn} = b;
      repeat (2) @(negedge clk);
      {Ubtn, Dbtn, Lbtn, Rbtn} = 4'b0;
      repeat (2) @(negedge clk);
   endtask
   task automatic enter(input logic [7:0] c);
      for (int i = 3; i >= 0; i--) begin
         logic [1:0] v;
         v = c[2*i+:2];
         press(4'b1000 >> v);
      end
   endtask
   task automatic pulse_prog();
      prog_req = 1'b1;
      repeat (2) @(negedge clk);
      prog_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask
   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask
   initial begin
      repeat (2) @(negedge clk);
      check("rst_ssg", {1'b0, SSG_D}, {1'b0, G0});
      check("rst_en", {5'b0, SSG_EN}, 8'h06);
      check("rst_flags", {5'b0, unlocked, locked_out, 1'b0}, 8'h00);
      check("rst_fail", {5'b0, fail_count}, 8'h00);
      reset = 1'b0;
      @(negedge clk);
      press(U); check("t1_d1", {1'b0, SSG_D}, {1'b0, G1});
      press(L); check("t1_d2", {1'b0, SSG_D}, {1'b0, G2});
      press(L); check("t1_d3", {1'b0, SSG_D}, {1'b0, G3});
      press(R); check("t1_open", {1'b0, SSG_D}, {1'b0, G9});
      check("t1_unl", {7'b0, unlocked}, 8'h01);
      check("t1_fail", {5'b0, fail_count}, 8'h00);
      press(U); check("t1_ignore", {1'b0, SSG_D}, {1'b0, G9});
      pulse_reset();
      press(U); press(D); press(L);
      check("t2_d3", {1'b0, SSG_D}, {1'b0, G3});
      press(R); check("t2_err", {1'b0, SSG_D}, {1'b0, GE});
      check("t2_fail1", {5'b0, fail_count}, 8'h01);
      press(U); check("t2_retry1", {1'b0, SSG_D}, {1'b0, G1});
      press(L); press(L); press(R);
      check("t2_open", {1'b0, SSG_D}, {1'b0, G9});
      check("t2_fail0", {5'b0, fail_count}, 8'h00);
      pulse_reset();
      enter(8'h00); check("t3_f1", {5'b0, fail_count}, 8'h01);
      enter(8'h00); check("t3_f2", {5'b0, fail_count}, 8'h02);
      enter(8'h00); check("t3_f3", {5'b0, fail_count}, 8'h03);
      check("t3_lo", {7'b0, locked_out}, 8'h01);
      check("t3_L", {1'b0, SSG_D}, {1'b0, GL});
      enter(8'h2B);
      check("t3_held_L", {1'b0, SSG_D}, {1'b0, GL});
      check("t3_held_f", {5'b0, fail_count}, 8'h03);
      repeat (12) @(negedge clk);
      check("t3_still_L", {1'b0, SSG_D}, {1'b0, GL});
      repeat (3) @(negedge clk);
      check("t3_exit_0", {1'b0, SSG_D}, {1'b0, G0});
      check("t3_exit_f", {5'b0, fail_count}, 8'h00);
      check("t3_exit_lo", {7'b0, locked_out}, 8'h00);
      enter(8'h2B); check("t3_open", {7'b0, unlocked}, 8'h01);
      pulse_prog(); check("t4_P", {1'b0, SSG_D}, {1'b0, GP});
      enter(8'hF4); check("t4_entry0", {1'b0, SSG_D}, {1'b0, G0});
      enter(8'h2B); check("t4_oldcode", {1'b0, SSG_D}, {1'b0, GE});
      enter(8'hF4); check("t4_newcode", {1'b0, SSG_D}, {1'b0, G9});
      check("t4_fail0", {5'b0, fail_count}, 8'h00);
      pulse_prog(); press(R);
      check("t5_prog_P", {1'b0, SSG_D}, {1'b0, GP});
      repeat (16) @(negedge clk);
      check("t5_prog_to", {1'b0, SSG_D}, {1'b0, G9});
      pulse_reset();
      press(U); press(L);
      check("t5_d2", {1'b0, SSG_D}, {1'b0, G2});
      repeat (16) @(negedge clk);
      check("t5_to_0", {1'b0, SSG_D}, {1'b0, G0});
      check("t5_to_f", {5'b0, fail_count}, 8'h00);
      enter(8'h2B); check("t5_after_to", {1'b0, SSG_D}, {1'b0, G9});
      pulse_reset();
      press(U | L); check("t6_inv_d1", {1'b0, SSG_D}, {1'b0, G1});
      press(L); press(L); press(R);
      check("t6_inv_E", {1'b0, SSG_D}, {1'b0, GE});
      pulse_reset();
      enter(8'h2B); pulse_prog(); enter(8'hF4);
      press(U); check("t6_mid_d1", {1'b0, SSG_D}, {1'b0, G1});
      pulse_reset();
      check("t6_mid_rst", {1'b0, SSG_D}, {1'b0, G0});
      enter(8'h2B); check("t6_revert", {1'b0, SSG_D}, {1'b0, G9});
      pulse_reset();
      enter(8'h00); enter(8'h00); enter(8'h00);
      check("t6_lo", {7'b0, locked_out}, 8'h01);
      pulse_reset();
      check("t6_lo_rst_ssg", {1'b0, SSG_D}, {1'b0, G0});
      check("t6_lo_rst_lo", {7'b0, locked_out}, 8'h00);
      check("t6_lo_rst_f", {5'b0, fail_count}, 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/code_lock_fsm.md
Name: code_lock_fsm

Overview:
- Parametrised successor to the 4-button password FSM on the Basys 3 board.
- Accepts a CODE_LEN-press code from the U/D/L/R buttons and shows progress and result on one seven-segment digit.
- Adds over the fixed-code block:
  - a runtime-programmable code;
  - a failed-attempt counter with timed lockout;
  - an inactivity timeout;
  - retry without reset.

Parameters:
- CODE_LEN, 4: presses per code, legal range 1..8.
- DEFAULT_CODE, 8'h2B: reset code, 2 bits per press, first press in the MSBs. Encoding U=0, D=1, L=2, R=3, so 8'h2B = U,L,L,R. Width is 2*CODE_LEN.
- MAX_TRIES, 3: consecutive failed attempts that trigger lockout.
- TIMEOUT_CYC, 1000: idle cycles before a partial entry is abandoned.
- LOCK_CYC, 5000: lockout duration in cycles.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- Ubtn, input, 1: up button, debounced and synchronous to clk.
- Dbtn, input, 1: down button.
- Lbtn, input, 1: left button.
- Rbtn, input, 1: right button.
- prog_req, input, 1: request to program a new code; honoured only in OPEN.
- SSG_D, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- SSG_EN, output, 3: digit enables, active-low; constant 3'b110.
- unlocked, output, 1: high in OPEN.
- locked_out, output, 1: high in LOCKOUT.
- fail_count, output, 3: consecutive failed attempts.

Behaviour:
- Reset (sync, at any time, any state):
  - state ENTRY, cnt=0, mismatch=0, fail_count=0, all timers 0;
  - code register loaded with DEFAULT_CODE;
  - SSG_D=7'b1000000 ("0"), SSG_EN=3'b110, unlocked=0, locked_out=0.
- Press detection:
  - A press is a button sampled 1 at the current edge and 0 at the previous edge.
  - All outputs are registered and update on the edge after the press is sampled (1-cycle latency).
  - Two or more rising edges in the same cycle count as one press of value "invalid": it always mismatches, and in PROG it aborts programming.
  - prog_req uses the same rising-edge rule.
- Press index i (0-based) is compared against code[2*(CODE_LEN-1-i)+:2].
- ENTRY:
  - Each press: cnt+1, mismatch |= (press != expected), idle timer cleared.
  - Display shows the decimal value of cnt.
  - On the CODE_LEN-th press:
    - if mismatch=0: go to OPEN and clear fail_count;
    - else: go to FAIL and increment fail_count, saturating at 7.
  - No early rejection: the full length is always collected.
- ENTRY timeout: if cnt>0 and TIMEOUT_CYC cycles pass with no press, then cnt=0 and mismatch=0. No failure is counted.
- OPEN:
  - Display "9" (7'b0010000), unlocked=1.
  - U/D/L/R are ignored.
  - A prog_req edge moves to PROG with pcnt=0.
- PROG:
  - Display "P" (7'b0001100).
  - Each valid press shifts into a shadow register and pcnt+1.
  - On the CODE_LEN-th press: shadow is committed to the code register, then go to ENTRY with cnt=0.
  - An invalid press or a TIMEOUT_CYC idle period aborts: code unchanged, return to OPEN.
- FAIL:
  - Display "E" (7'b0000110).
  - If fail_count == MAX_TRIES, go to LOCKOUT on the next cycle.
  - Otherwise, the next press starts a new attempt: it is evaluated as press index 0, leaves cnt=1, and the state becomes ENTRY.
- LOCKOUT:
  - Display "L" (7'b1000111), locked_out=1.
  - All inputs except reset are ignored for exactly LOCK_CYC cycles.
  - Then: ENTRY, cnt=0, fail_count=0.
- Digit glyphs 0..8: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000.
- A button held high produces one press only; releasing and re-pressing is required for another.

Test Plan:
Bench parameters: CODE_LEN=4, TIMEOUT_CYC=16, LOCK_CYC=32, 20 ns clock, presses 2 cycles high and 2 cycles low.
1. Reset, then U,L,L,R:
   - SSG_D steps 0→1→2→3, then 7'b0010000;
   - unlocked=1, fail_count=0;
   - a following U press leaves the display on "9".
2. Reset, then U,D,L,R:
   - display 0..3, then 7'b0000110, fail_count=1;
   - then U,L,L,R: display 1,2,3, then "9", fail_count=0.
3. Three wrong 4-press codes:
   - fail_count 1,2,3; locked_out=1; display "L";
   - presses during lockout have no effect;
   - after 32 cycles: display "0", fail_count=0, and the correct code unlocks.
4. Unlock, pulse prog_req, enter R,R,D,U:
   - returns to ENTRY showing "0";
   - U,L,L,R then gives "E";
   - R,R,D,U gives "9".
5. Timeout:
   - U,L, then idle 16 cycles: display "0", no fail counted;
   - in PROG, enter R then idle 16 cycles: back to "9", code unchanged.
6. Invalid presses and mid-operation reset:
   - U and L rising in the same cycle at index 0 → final result "E";
   - reset asserted mid-entry or during LOCKOUT → next cycle display "0", locked_out=0, and the code reverts to 8'h2B.
